// File: rtl/lsu_bus_if.sv
// Load/store bus interface: turns controller load/store requests into a req/ack bus transaction,
// stalling the core until done. Optional bus timeout abort is enabled by defining LSU_TIMEOUT_EN.
module lsu_bus_if #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwen,
  input  logic        memren,
  input  logic [2:0]  d_mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("lsu_bus_if: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t      state, state_nxt;
  logic        op, start, ack_hit, timeout_hit;
  logic [2:0]  mode, mode_q;
  logic        is_word, is_half, is_byte;
  logic [1:0]  lane, lane_q;
  logic [3:0]  st_strb;
  logic [31:0] st_data, ld_data, rdata_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Reserved modes 5..7 behave as word accesses.
  assign mode    = (d_mode > 3'd4) ? 3'd0 : d_mode;
  assign is_word = (mode == 3'd0);
  assign is_half = (mode == 3'd1) || (mode == 3'd3);
  assign is_byte = (mode == 3'd2) || (mode == 3'd4);
  assign lane    = addr[1:0];

  assign op       = memwen | memren;
  assign misalign = op && ((is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00)));
  assign start    = (state == IDLE) && op && !misalign;
  assign ack_hit  = (state == REQ) && bus_ack;

  assign stall   = op && !misalign && (state != DONE);
  assign done    = (state == DONE);
  assign bus_req = (state == REQ);
  assign rdata   = misalign ? 32'd0 : rdata_q;

`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt;
  logic        err_q;

  // The cycle whose increment would reach the limit is the last REQ cycle.
  assign timeout_hit = (state == REQ) && !bus_ack && (to_cnt == TO_LAST);
  assign bus_err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (start)
        to_cnt <= '0;
      else if ((state == REQ) && !bus_ack)
        to_cnt <= to_cnt + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  // NOTE: every signal driven in an always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     if (ack_hit || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    st_strb = 4'b1111;
    st_data = wdata;
    if (is_byte) begin
      st_strb = 4'b0001 << lane;
      st_data = {4{wdata[7:0]}};
    end else if (is_half) begin
      st_strb = lane[1] ? 4'b1100 : 4'b0011;
      st_data = {2{wdata[15:0]}};
    end
  end

  // Extraction uses the lane/mode captured at request time, not the live inputs.
  always_comb begin
    ld_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    unique case (lane_q)
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    unique case (mode_q)
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd2:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd3:    ld_data = {16'd0, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      default: ld_data = bus_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
      lane_q    <= '0;
      mode_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        bus_we    <= memwen;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_wstrb <= memwen ? st_strb : 4'b0000;
        bus_wdata <= st_data;
        lane_q    <= lane;
        mode_q    <= mode;
      end
      if (ack_hit && !bus_we)
        rdata_q <= ld_data;
      else if (timeout_hit)
        rdata_q <= '0;
    end
  end

endmodule

// File: tb/tb_lsu_bus_if.sv
// Directed self-checking bench for lsu_bus_if; the timeout scenario runs when LSU_TIMEOUT_EN is defined.
module tb_lsu_bus_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memwen = 1'b0, memren = 1'b0;
  logic [2:0]  d_mode = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        stall, done, misalign, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;

  lsu_bus_if #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .memwen(memwen), .memren(memren), .d_mode(d_mode),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done),
    .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access: op in cycle 0, ack in cycle n, DONE in cycle n+1, op dropped afterwards.
  task automatic access(input string tag, input logic we, input logic re, input logic [2:0] mode,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdv,
                        input int n);
    memwen = we; memren = re; d_mode = mode; addr = a; wdata = wd; bus_ack = 1'b0;
    #1;
    check({tag, " stall c0"}, 32'(stall), 32'd1);
    for (int c = 1; c <= n; c++) begin
      step();
      if (c == n) begin
        bus_ack = 1'b1;
        bus_rdata = rdv;
      end
      #1;
      check({tag, " bus_req"}, 32'(bus_req), 32'd1);
      check({tag, " bus_addr"}, bus_addr, {a[31:2], 2'b00});
      if (c == 1) begin
        cap_we = bus_we; cap_addr = bus_addr; cap_wstrb = bus_wstrb; cap_wdata = bus_wdata;
      end
    end
    step();
    bus_ack = 1'b0;
    #1;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " stall done"}, 32'(stall), 32'd0);
    check({tag, " bus_err"}, 32'(bus_err), 32'd0);
  endtask

  task automatic finish_access(input string tag);
    memwen = 1'b0; memren = 1'b0;
    step();
    check({tag, " idle done"}, 32'(done), 32'd0);
    check({tag, " idle req"}, 32'(bus_req), 32'd0);
  endtask

  initial begin
    // Reset state
    step(); step();
    rst = 1'b0;
    #1;
    check("rst rdata", rdata, 32'd0);
    check("rst bus_req", 32'(bus_req), 32'd0);
    check("rst bus_addr", bus_addr, 32'd0);
    check("rst bus_wdata", bus_wdata, 32'd0);
    check("rst bus_wstrb", 32'(bus_wstrb), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    check("rst bus_err", 32'(bus_err), 32'd0);

    // lw 0x100, ack 3 cycles after req
    access("lw", 1'b0, 1'b1, 3'd0, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    check("lw rdata", rdata, 32'hDEADBEEF);
    check("lw we", 32'(cap_we), 32'd0);
    finish_access("lw");
    check("lw rdata held", rdata, 32'hDEADBEEF);

    // Byte and half loads with sign/zero extension
    access("lb", 1'b0, 1'b1, 3'd2, 32'h203, 32'h0, 32'h80AA5511, 1);
    check("lb rdata", rdata, 32'hFFFFFF80);
    finish_access("lb");
    access("lbu", 1'b0, 1'b1, 3'd4, 32'h203, 32'h0, 32'h80AA5511, 1);
    check("lbu rdata", rdata, 32'h00000080);
    finish_access("lbu");
    access("lh", 1'b0, 1'b1, 3'd1, 32'h102, 32'h0, 32'h80AA5511, 2);
    check("lh rdata", rdata, 32'hFFFF80AA);
    finish_access("lh");
    access("lhu", 1'b0, 1'b1, 3'd3, 32'h100, 32'h0, 32'h80AA5511, 1);
    check("lhu rdata", rdata, 32'h00005511);
    finish_access("lhu");
    access("lb1", 1'b0, 1'b1, 3'd2, 32'h201, 32'h0, 32'h80AA5511, 1);
    check("lb1 rdata", rdata, 32'h00000055);
    finish_access("lb1");
    access("lw7", 1'b0, 1'b1, 3'd7, 32'h104, 32'h0, 32'h12345678, 1);
    check("lw7 rdata", rdata, 32'h12345678);
    finish_access("lw7");

    // Stores: strobes, lane replication, rdata untouched
    access("sh", 1'b1, 1'b0, 3'd1, 32'h42, 32'h1234ABCD, 32'hFFFFFFFF, 1);
    check("sh we", 32'(cap_we), 32'd1);
    check("sh addr", cap_addr, 32'h40);
    check("sh wstrb", 32'(cap_wstrb), 32'hC);
    check("sh wdata", cap_wdata, 32'hABCDABCD);
    check("sh rdata kept", rdata, 32'h12345678);
    finish_access("sh");
    access("sb", 1'b1, 1'b0, 3'd2, 32'h41, 32'h000000EE, 32'h0, 2);
    check("sb wstrb", 32'(cap_wstrb), 32'h2);
    check("sb wdata", cap_wdata, 32'hEEEEEEEE);
    finish_access("sb");
    access("sw both", 1'b1, 1'b1, 3'd0, 32'h80, 32'hCAFEF00D, 32'h0, 1);
    check("sw we", 32'(cap_we), 32'd1);
    check("sw wstrb", 32'(cap_wstrb), 32'hF);
    check("sw wdata", cap_wdata, 32'hCAFEF00D);
    check("sw rdata kept", rdata, 32'h12345678);
    finish_access("sw");

    // Misaligned accesses retire immediately without a bus cycle
    memren = 1'b1; d_mode = 3'd0; addr = 32'h101;
    #1;
    check("mis lw flag", 32'(misalign), 32'd1);
    check("mis lw stall", 32'(stall), 32'd0);
    check("mis lw rdata", rdata, 32'd0);
    step();
    check("mis lw req", 32'(bus_req), 32'd0);
    memren = 1'b0; memwen = 1'b1; d_mode = 3'd1; addr = 32'h43;
    #1;
    check("mis sh flag", 32'(misalign), 32'd1);
    check("mis sh stall", 32'(stall), 32'd0);
    step();
    check("mis sh req", 32'(bus_req), 32'd0);
    check("mis sh done", 32'(done), 32'd0);
    memwen = 1'b0;
    #1;
    check("aligned flag", 32'(misalign), 32'd0);

    // Ack outside REQ is ignored
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
    check("stray ack done", 32'(done), 32'd0);
    check("stray ack req", 32'(bus_req), 32'd0);

    // Inputs changed during REQ have no effect
    memren = 1'b1; d_mode = 3'd0; addr = 32'h300;
    step();
    addr = 32'h500; d_mode = 3'd2;
    step();
    check("hold addr", bus_addr, 32'h300);
    bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5;
    step();
    bus_ack = 1'b0;
    #1;
    check("hold rdata", rdata, 32'hA5A5A5A5);
    finish_access("hold");

`ifdef LSU_TIMEOUT_EN
    // Timeout with TIMEOUT_CYCLES=4 and no ack
    memren = 1'b1; d_mode = 3'd0; addr = 32'h200;
    for (int c = 1; c <= 4; c++) begin
      step();
      check("to req", 32'(bus_req), 32'd1);
    end
    step();
    check("to bus_err", 32'(bus_err), 32'd1);
    check("to done", 32'(done), 32'd1);
    check("to req low", 32'(bus_req), 32'd0);
    check("to rdata", rdata, 32'd0);
    memren = 1'b0;
    step();
    check("to idle done", 32'(done), 32'd0);
    check("to idle err", 32'(bus_err), 32'd0);
`endif

    // Reset mid-REQ abandons the transfer; a late ack is ignored
    memren = 1'b1; d_mode = 3'd0; addr = 32'h100;
    step();
    check("mr req", 32'(bus_req), 32'd1);
    step();
    rst = 1'b1; memren = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("mr req low", 32'(bus_req), 32'd0);
    check("mr stall", 32'(stall), 32'd0);
    check("mr rdata", rdata, 32'd0);
    step();
    bus_ack = 1'b1; bus_rdata = 32'h11111111;
    step();
    bus_ack = 1'b0;
    #1;
    check("mr late done", 32'(done), 32'd0);
    check("mr late req", 32'(bus_req), 32'd0);
    check("mr late rdata", rdata, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
